// File: rtl/rx_ptp_buf_reader.sv
// RX PTP buffer reader: drains one frame from the RX buffer over the
// on-chip bus and streams it to the PTP parser with backpressure.
module rx_ptp_buf_reader #(
    parameter logic [31:0] RX_BUF_BADDR = 32'h1000,
    parameter int          MAX_LEN      = 504
) (
    input  logic        bus2ip_clk,
    input  logic        bus2ip_rst,
    input  logic        ctrl_en_i,
    input  logic        frame_rdy_i,
    output logic [31:0] bus2ip_addr_o,
    output logic        bus2ip_rd_ce_o,
    input  logic [31:0] ip2bus_data_i,
    output logic [31:0] frm_data_o,
    output logic [3:0]  frm_be_o,
    output logic        frm_valid_o,
    output logic        frm_sop_o,
    output logic        frm_eop_o,
    output logic        frm_err_o,
    input  logic        frm_ready_i,
    output logic [15:0] drop_cnt_o,
    output logic [15:0] ovr_cnt_o,
    output logic        busy_o
);

    localparam logic [8:0] MAX_L = 9'(MAX_LEN);

    typedef enum logic [2:0] {
        IDLE,
        RD_LEN,
        CHK,
        RD_WORD,
        DRAIN
    } state_t;

    state_t     state;
    logic       pend;
    logic       ovr;
    logic [8:0] len;
    logic [6:0] words;
    logic [6:0] idx;
    logic       can_load;
    logic       eop_acc;
    logic       last;
    logic [3:0] last_be;
    logic [9:0] len_rnd;

    assign can_load = !frm_valid_o || frm_ready_i;
    assign eop_acc  = frm_valid_o && frm_eop_o && frm_ready_i;
    assign last     = (idx == words - 7'd1);
    assign busy_o   = (state != IDLE);
    assign len_rnd  = {1'b0, len} + 10'd3;

    always_comb begin
        unique case (len[1:0])
            2'd0:    last_be = 4'hF;
            2'd1:    last_be = 4'h1;
            2'd2:    last_be = 4'h3;
            default: last_be = 4'h7;
        endcase
    end

    // Bus read is combinational so the data lands in the same cycle.
    always_comb begin
        bus2ip_rd_ce_o = 1'b0;
        bus2ip_addr_o  = 32'h0;
        if (state == RD_LEN) begin
            bus2ip_rd_ce_o = 1'b1;
            bus2ip_addr_o  = RX_BUF_BADDR + 32'h200;
        end else if (state == RD_WORD && can_load) begin
            bus2ip_rd_ce_o = 1'b1;
            bus2ip_addr_o  = RX_BUF_BADDR + {23'h0, idx, 2'b00};
        end
    end

    always_ff @(posedge bus2ip_clk) begin
        if (bus2ip_rst) begin
            state       <= IDLE;
            pend        <= 1'b0;
            ovr         <= 1'b0;
            len         <= 9'h0;
            words       <= 7'h0;
            idx         <= 7'h0;
            frm_data_o  <= 32'h0;
            frm_be_o    <= 4'h0;
            frm_valid_o <= 1'b0;
            frm_sop_o   <= 1'b0;
            frm_eop_o   <= 1'b0;
            frm_err_o   <= 1'b0;
            drop_cnt_o  <= 16'h0;
            ovr_cnt_o   <= 16'h0;
        end else begin
            if (frame_rdy_i && ctrl_en_i)
                pend <= 1'b1;
            if (frame_rdy_i && (state == RD_WORD || state == DRAIN))
                ovr <= 1'b1;
            // A stalled EOP still learns about a late overwrite.
            if (frm_valid_o && frm_eop_o && !frm_ready_i && frame_rdy_i)
                frm_err_o <= 1'b1;
            if (eop_acc) begin
                ovr <= 1'b0;
                if ((ovr || frame_rdy_i) && ovr_cnt_o != 16'hFFFF)
                    ovr_cnt_o <= ovr_cnt_o + 16'd1;
            end
            if (frm_valid_o && frm_ready_i) begin
                frm_valid_o <= 1'b0;
                frm_sop_o   <= 1'b0;
                frm_eop_o   <= 1'b0;
                frm_err_o   <= 1'b0;
                frm_be_o    <= 4'h0;
                frm_data_o  <= 32'h0;
            end
            unique case (state)
                IDLE: begin
                    if (pend || (frame_rdy_i && ctrl_en_i)) begin
                        state <= RD_LEN;
                        pend  <= 1'b0;
                    end
                end
                RD_LEN: begin
                    len   <= ip2bus_data_i[8:0];
                    state <= CHK;
                end
                CHK: begin
                    if (len == 9'h0 || len > MAX_L) begin
                        if (drop_cnt_o != 16'hFFFF)
                            drop_cnt_o <= drop_cnt_o + 16'd1;
                        state <= IDLE;
                    end else begin
                        words <= len_rnd[8:2];
                        idx   <= 7'h0;
                        state <= RD_WORD;
                    end
                end
                RD_WORD: begin
                    if (can_load) begin
                        frm_data_o  <= ip2bus_data_i;
                        frm_valid_o <= 1'b1;
                        frm_sop_o   <= (idx == 7'h0);
                        frm_eop_o   <= last;
                        frm_be_o    <= last ? last_be : 4'hF;
                        frm_err_o   <= last && (ovr || frame_rdy_i);
                        idx         <= idx + 7'd1;
                        if (last)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (eop_acc)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_ptp_buf_reader.sv
// Directed bench for rx_ptp_buf_reader with a behavioural RX buffer
// and hand-computed stream expectations.
module tb_rx_ptp_buf_reader;

    localparam logic [31:0] BADDR = 32'h1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        rdy = 1'b0;
    logic        ready = 1'b1;
    logic [31:0] addr;
    logic        rd_ce;
    logic [31:0] rdata;
    logic [31:0] fdata;
    logic [3:0]  fbe;
    logic        fvalid, fsop, feop, ferr;
    logic [15:0] drop_cnt, ovr_cnt;
    logic        busy;

    logic [31:0] mem [0:127];
    logic [31:0] len_reg = 32'h0;
    int nchk = 0;
    int nerr = 0;
    int cyc = 0;

    rx_ptp_buf_reader dut (
        .bus2ip_clk     (clk),
        .bus2ip_rst     (rst),
        .ctrl_en_i      (en),
        .frame_rdy_i    (rdy),
        .bus2ip_addr_o  (addr),
        .bus2ip_rd_ce_o (rd_ce),
        .ip2bus_data_i  (rdata),
        .frm_data_o     (fdata),
        .frm_be_o       (fbe),
        .frm_valid_o    (fvalid),
        .frm_sop_o      (fsop),
        .frm_eop_o      (feop),
        .frm_err_o      (ferr),
        .frm_ready_i    (ready),
        .drop_cnt_o     (drop_cnt),
        .ovr_cnt_o      (ovr_cnt),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        rdata = 32'h0;
        if (rd_ce) begin
            if (addr == BADDR + 32'h200)
                rdata = len_reg;
            else
                rdata = mem[addr[8:2]];
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [7:0] tag,
                                            input int k);
        logic [7:0] kb;
        kb = 8'(k);
        return {tag, 8'h5A, kb, ~kb};
    endfunction

    function automatic logic [3:0] be_of(input int len);
        case (len % 4)
            0: return 4'hF;
            1: return 4'h1;
            2: return 4'h3;
            default: return 4'h7;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic load(input int len, input logic [7:0] tag);
        len_reg = 32'hDEAD0000 | 32'(len);
        for (int k = 0; k < 128; k++)
            mem[k] = word_of(tag, k);
    endtask

    task automatic pulse();
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        #1;
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: notify at word 5
    task automatic recv(input int len, input logic [7:0] tag,
                        input int mode, input logic exp_err,
                        output int first_c, output int eop_c);
        int n;
        int k;
        int guard;
        logic held;
        logic [31:0] hold_d;
        logic hold_s;
        n = (len + 3) / 4;
        k = 0;
        guard = 0;
        held = 1'b0;
        hold_d = 32'h0;
        hold_s = 1'b0;
        first_c = -1;
        eop_c = -1;
        while (1) begin
            if (mode == 1)
                ready = (guard % 4 == 0) || (guard % 4 == 3);
            else
                ready = 1'b1;
            rdy = (mode == 2) && (k == 5) && fvalid;
            #1;
            if (held) begin
                check("hold_data", fdata, hold_d);
                check("hold_sop", 32'(fsop), 32'(hold_s));
            end
            held = fvalid && !ready;
            if (held) begin
                hold_d = fdata;
                hold_s = fsop;
                check("no_rd_full", 32'(rd_ce), 32'h0);
            end
            if (fvalid && ready) begin
                if (k == 0)
                    first_c = cyc;
                check("data", fdata, word_of(tag, k));
                check("sop", 32'(fsop), 32'(k == 0));
                check("eop", 32'(feop), 32'(k == n - 1));
                check("be", 32'(fbe), 32'((k == n - 1) ? be_of(len) : 4'hF));
                if (k == n - 1) begin
                    check("err", 32'(ferr), 32'(exp_err));
                    eop_c = cyc;
                end
                k++;
            end
            if (k == n || guard >= 600)
                break;
            step();
            guard++;
        end
        rdy = 1'b0;
        check("frame_done", 32'(k), 32'(n));
    endtask

    initial begin
        int p0;
        int fc;
        int ec;
        int lens [4];
        lens = '{61, 1, 7, 10};
        load(60, 8'hA1);
        step();
        step();
        check("rst_valid", 32'(fvalid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_rdce", 32'(rd_ce), 32'h0);
        check("rst_cnts", {drop_cnt, ovr_cnt}, 32'h0);
        check("rst_data", fdata, 32'h0);
        rst = 1'b0;
        en = 1'b1;
        step();

        // length 60, latency and throughput
        p0 = cyc;
        pulse();
        check("rdlen_ce", 32'(rd_ce), 32'h1);
        check("rdlen_addr", addr, 32'h1200);
        step();
        check("chk_ce", 32'(rd_ce), 32'h0);
        check("chk_addr", addr, 32'h0);
        step();
        check("w0_addr", addr, 32'h1000);
        recv(60, 8'hA1, 0, 1'b0, fc, ec);
        check("sop_lat", 32'(fc - p0), 32'd4);
        check("eop_lat", 32'(ec - p0), 32'd18);
        step();
        check("idle_busy", 32'(busy), 32'h0);
        check("idle_valid", 32'(fvalid), 32'h0);

        // byte-enable variants
        for (int i = 0; i < 4; i++) begin
            load(lens[i], 8'(8'hB0 + i));
            p0 = cyc;
            pulse();
            recv(lens[i], 8'(8'hB0 + i), 0, 1'b0, fc, ec);
            check("var_lat", 32'(ec - p0), 32'(3 + (lens[i] + 3) / 4));
            step();
            step();
        end

        // illegal lengths
        load(0, 8'hC0);
        pulse();
        step();
        check("drop0_busy2", 32'(busy), 32'h1);
        step();
        check("drop0_busy3", 32'(busy), 32'h0);
        check("drop0_valid", 32'(fvalid), 32'h0);
        check("drop0_cnt", 32'(drop_cnt), 32'd1);
        load(505, 8'hC1);
        pulse();
        step();
        step();
        check("drop505_busy3", 32'(busy), 32'h0);
        check("drop505_valid", 32'(fvalid), 32'h0);
        check("drop505_cnt", 32'(drop_cnt), 32'd2);
        load(504, 8'hC2);
        pulse();
        recv(504, 8'hC2, 0, 1'b0, fc, ec);
        step();
        check("max_nodrop", 32'(drop_cnt), 32'd2);

        // disabled notifications are ignored
        en = 1'b0;
        pulse();
        check("dis_busy", 32'(busy), 32'h0);
        step();
        check("dis_busy2", 32'(busy), 32'h0);
        en = 1'b1;

        // backpressure
        load(64, 8'hD0);
        pulse();
        recv(64, 8'hD0, 1, 1'b0, fc, ec);
        ready = 1'b1;
        step();
        check("bp_busy", 32'(busy), 32'h0);

        // overrun during word 5, then newest frame read next
        load(64, 8'hE0);
        pulse();
        recv(64, 8'hE0, 2, 1'b1, fc, ec);
        step();
        check("ovr_cnt", 32'(ovr_cnt), 32'd1);
        check("ovr_idle", 32'(busy), 32'h0);
        step();
        check("ovr_rdlen", 32'(rd_ce), 32'h1);
        check("ovr_rdaddr", addr, 32'h1200);
        recv(64, 8'hE0, 0, 1'b0, fc, ec);
        step();
        check("ovr_cnt2", 32'(ovr_cnt), 32'd1);

        // reset mid-frame at word 3
        load(64, 8'hF0);
        ready = 1'b1;
        p0 = cyc;
        pulse();
        for (int i = 0; i < 6; i++)
            step();
        check("pre_rst_w3", fdata, word_of(8'hF0, 3));
        rst = 1'b1;
        step();
        check("mr_valid", 32'(fvalid), 32'h0);
        check("mr_flags", {28'h0, fsop, feop, ferr, busy}, 32'h0);
        check("mr_data", {fdata[31:4], fbe}, 32'h0);
        check("mr_bus", addr | 32'(rd_ce), 32'h0);
        check("mr_cnts", {drop_cnt, ovr_cnt}, 32'h0);
        rst = 1'b0;
        step();
        load(12, 8'hF1);
        p0 = cyc;
        pulse();
        recv(12, 8'hF1, 0, 1'b0, fc, ec);
        check("post_rst_lat", 32'(fc - p0), 32'd4);
        step();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
